// File: rtl/ram_latency.sv
// rtl/ram_latency.sv - dual-port RAM wrapper with per-port response latency and LFSR grant stalls

// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1); free-running, never locks up from a nonzero seed
module ram_latency_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);
    logic feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    // Advance every cycle, independent of request activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], feedback};
        end
    end
endmodule

// Word-addressed storage: one combinational read port, one read/write port with byte enables.
// Writes land on the clock edge, so a same-cycle read on the other port still sees the old word.
module ram_latency_dp_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    output logic [31:0]   a_rdata,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [3:0]    b_be,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);
    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    assign a_rdata = mem[a_addr];
    assign b_rdata = mem[b_addr];

    // Byte-masked write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (b_we) begin
            for (int b = 0; b < 4; b++) begin
                if (b_be[b]) begin
                    mem[b_addr][8*b +: 8] <= b_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// Response pipeline: stage 0 registers the storage read, LATENCY-1 further stages follow.
// Data only moves with its valid bit, so the output holds the last response between responses.
module ram_latency_resp_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data
);
    logic [LATENCY-1:0] valid;
    logic [31:0]        data [LATENCY];

    assign out_valid = valid[LATENCY-1];
    assign out_data  = data[LATENCY-1];

    // Shift valid every cycle; shift data only alongside a valid response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data[i] <= '0;
            end
        end else begin
            valid[0] <= in_valid;
            if (in_valid) begin
                data[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid[i] <= valid[i-1];
                if (valid[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end
endmodule

module ram_latency #(
    parameter int          ADDR_WIDTH    = 16,
    parameter int          INSTR_LATENCY = 1,
    parameter int          DATA_LATENCY  = 1,
    parameter int          STALL_EN      = 0,
    parameter logic [15:0] INSTR_SEED    = 16'hACE1,
    parameter logic [15:0] DATA_SEED     = 16'h1D2C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o
);
    localparam int WAW = ADDR_WIDTH - 2;

    logic [15:0] instr_lfsr;
    logic [15:0] data_lfsr;
    logic        instr_accept;
    logic        data_accept;
    logic [31:0] instr_raw;
    logic [31:0] data_raw;
    logic        unused_addr_bits;

    // Byte offset within a word never matters: accesses are whole-word with byte enables
    assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    ram_latency_lfsr #(.SEED(INSTR_SEED)) u_instr_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (instr_lfsr)
    );

    ram_latency_lfsr #(.SEED(DATA_SEED)) u_data_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (data_lfsr)
    );

    // Grants are combinational; held low while reset is asserted
    assign instr_gnt_o  = instr_req_i & rst_n & ((STALL_EN == 0) | (instr_lfsr[1:0] != 2'b00));
    assign data_gnt_o   = data_req_i  & rst_n & ((STALL_EN == 0) | (data_lfsr[1:0]  != 2'b00));
    assign instr_accept = instr_req_i & instr_gnt_o;
    assign data_accept  = data_req_i  & data_gnt_o;

    ram_latency_dp_ram #(.AW(WAW)) u_ram (
        .clk     (clk),
        .a_addr  (instr_addr_i[ADDR_WIDTH-1:2]),
        .a_rdata (instr_raw),
        .b_addr  (data_addr_i[ADDR_WIDTH-1:2]),
        .b_we    (data_accept & data_we_i),
        .b_be    (data_be_i),
        .b_wdata (data_wdata_i),
        .b_rdata (data_raw)
    );

    ram_latency_resp_pipe #(.LATENCY(INSTR_LATENCY)) u_instr_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (instr_accept),
        .in_data   (instr_raw),
        .out_valid (instr_rvalid_o),
        .out_data  (instr_rdata_o)
    );

    // Writes also travel this pipe so they get their single response; their rdata is don't-care
    ram_latency_resp_pipe #(.LATENCY(DATA_LATENCY)) u_data_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (data_accept),
        .in_data   (data_raw),
        .out_valid (data_rvalid_o),
        .out_data  (data_rdata_o)
    );
endmodule
